mdio_responder: RTL and testbench
=================================

// Module: mdio_responder
// PURPOSE
//  PHY-side MDIO management responder (Clause 22): the counterpart to the MAC's MIIM
//  initiator. Decodes MDC/MDIO frames, serves reads from a 32x16 register file and
//  applies writes. Used as the on-chip PHY management model in the bridge and as the
//  bench responder for the MAC's MIIM path. MDC is oversampled in the clk domain.
// PARAMETERS
//  PHY_ADDR      5'd1      address this responder answers to
//  PREAMBLE_LEN  32        consecutive 1s required before ST (1..32)
//  PHY_ID1       16'h0022  read-only value of reg 2
//  PHY_ID2       16'h1622  read-only value of reg 3
// PORTS
//  clk          in   1   system clock; must be >= 4x MDC frequency
//  reset        in   1   synchronous, active-low reset
//  mdc          in   1   management clock from the MAC (asynchronous to clk)
//  mdio_in      in   1   MDIO pad input
//  mdio_out     out  1   MDIO drive value
//  mdio_oen     out  1   output enable, active low (0 = drive mdio_out)
//  status_in    in   16  live value returned for reg 1 (read-only)
//  reg_wr_en    out  1   1-clk pulse when an addressed write completes
//  reg_wr_addr  out  5   register address of that write
//  reg_wr_data  out  16  data of that write
// BEHAVIOUR
//  Reset (reset=0 at posedge clk): FSM=IDLE, mdio_oen=1, mdio_out=1, reg_wr_en=0,
//   reg_wr_addr=0, reg_wr_data=0, preamble count=0, regs 0 and 4..31 = 16'h0000.
//   Reset mid-frame aborts the frame and releases MDIO the same cycle.
//  Sync: mdc and mdio_in each pass 2 FFs; rise/fall detected on synced mdc. Bits are
//   sampled on detected mdc rise; outputs update in the clk after detected mdc fall.
//  Frame: PRE(>=PREAMBLE_LEN 1s) ST=01 OP(10 rd, 01 wr) PHYAD[5] REGAD[5] TA DATA[16],
//   all MSB first.
//  FSM states, one transition per sampled bit:
//   IDLE:  count consecutive 1s, saturate at PREAMBLE_LEN; a 0 clears count; a 0 with
//          count==PREAMBLE_LEN -> ST2 (that 0 is ST bit 1).
//   ST2:   1 -> OP; 0 -> IDLE (count=0).
//   OP:    2 bits; 00 or 11 -> IDLE (count=0).
//   PHYAD: 5 bits; REGAD: 5 bits; on last REGAD bit, PHYAD!=PHY_ADDR -> SKIP, else
//          read latches rd_shift from reg file (reg1=status_in, reg2/3=IDs) -> TA.
//   TA:    2 bits. Read: stay released for bit 1; after fall following TA bit 1,
//          drive 0 (oen=0). Write: TA bits ignored (not checked).
//   DATA:  16 bits. Read: drive rd_shift MSB first, one bit per mdc fall; at the mdc
//          fall after the 16th bit, release (oen=1, out=1) -> IDLE. Write: shift in
//          sampled bits; after 16th -> commit -> IDLE.
//   SKIP:  count 18 bits (TA+DATA) without driving -> IDLE.
//  Return to IDLE always clears the preamble count (next frame needs a full preamble).
//  Commit: regs 2,3 and 1 are read-only (write still pulses reg_wr_en, no update).
//   Reg 0 bit 15 is self-clearing soft reset: writing 1 restores regs 0,4..31 to
//   16'h0000 and reg 0 reads 0; otherwise write stores data. reg_wr_en pulses one
//   clk in the commit cycle; addr/data hold until next commit.
//  mdio_oen=0 only from the TA-drive point to end of DATA of an addressed read.
//  Read-after-write to same reg in the next frame returns the written value.
// TESTING
//  1) 32x1, 01, 01, PHY_ADDR, reg 4, 10, 16'hA5C3 -> reg_wr_en 1 clk, addr 4, data A5C3.
//  2) Read reg 4 after (1) -> mdio_oen low from TA bit 2 to bit 16, serial 0,A5C3 MSB first.
//  3) Read reg 2 / reg 3 -> 16'h0022 / 16'h1622; read reg 1 with status_in=16'h786D -> 786D.
//  4) Read with PHYAD=PHY_ADDR+1 -> mdio_oen stays 1 whole frame; next valid frame OK.
//  5) Preamble of 31 1s then valid frame -> ignored; OP=11 -> ignored, no reg_wr_en.
//  6) Assert reset mid-DATA of a read -> oen=1 next clk; write 16'h8000 to reg 0 -> regs
//     0,4..31 read 0; mdc at clk/4 with random phase -> all above still pass.

Source files
------------

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder with a 32x16 register file; MDC oversampled in clk.
// Latency: MDIO drive changes 3 clk after an MDC fall; no backpressure (MDC-paced).
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic [15:0] status_in,
    output logic        reg_wr_en,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
    } state_t;

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

    // [0],[1] are the synchroniser stages, [2] holds the previous synced level
    logic [2:0] mdc_sync;
    logic [1:0] mdio_sync;
    logic       mdc_rise, mdc_fall, bit_in;

    always_ff @(posedge clk) begin
        mdc_sync  <= {mdc_sync[1:0], mdc};
        mdio_sync <= {mdio_sync[0], mdio_in};
    end

    assign mdc_rise = mdc_sync[1] & ~mdc_sync[2];
    assign mdc_fall = ~mdc_sync[1] & mdc_sync[2];
    assign bit_in   = mdio_sync[1];

    state_t      state, state_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [5:0]  pre_cnt, pre_cnt_nxt;
    logic        is_rd, is_rd_nxt;
    logic        op_hi, op_hi_nxt;
    logic [4:0]  phy_sh, phy_sh_nxt;
    logic [4:0]  reg_sh, reg_sh_nxt;
    logic [15:0] rd_shift, rd_shift_nxt;
    logic [15:0] wr_shift, wr_shift_nxt;
    logic        out_nxt, oen_nxt;
    logic        commit;

    logic [15:0] regs [32];
    logic [4:0]  reg_addr_full;
    logic [15:0] rd_val;
    logic [15:0] wr_data_full;

    assign reg_addr_full = {reg_sh[3:0], bit_in};
    assign wr_data_full  = {wr_shift[14:0], bit_in};

    always_comb begin
        rd_val = regs[reg_addr_full];
        case (reg_addr_full)
            5'd1:    rd_val = status_in;
            5'd2:    rd_val = PHY_ID1;
            5'd3:    rd_val = PHY_ID2;
            default: rd_val = regs[reg_addr_full];
        endcase
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        pre_cnt_nxt  = pre_cnt;
        is_rd_nxt    = is_rd;
        op_hi_nxt    = op_hi;
        phy_sh_nxt   = phy_sh;
        reg_sh_nxt   = reg_sh;
        rd_shift_nxt = rd_shift;
        wr_shift_nxt = wr_shift;
        out_nxt      = mdio_out;
        oen_nxt      = mdio_oen;
        commit       = 1'b0;

        if (mdc_rise) begin
            case (state)
                S_IDLE: begin
                    if (bit_in) begin
                        if (pre_cnt != PRE_MAX) pre_cnt_nxt = pre_cnt + 6'd1;
                    end else begin
                        pre_cnt_nxt = 6'd0;
                        if (pre_cnt == PRE_MAX) state_nxt = S_ST2;
                    end
                end
                S_ST2: begin
                    bit_cnt_nxt = 5'd0;
                    state_nxt   = bit_in ? S_OP : S_IDLE;
                end
                S_OP: begin
                    if (bit_cnt == 5'd0) begin
                        op_hi_nxt   = bit_in;
                        bit_cnt_nxt = 5'd1;
                    end else if (op_hi != bit_in) begin
                        is_rd_nxt   = op_hi;
                        bit_cnt_nxt = 5'd0;
                        state_nxt   = S_PHYAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_PHYAD: begin
                    phy_sh_nxt = {phy_sh[3:0], bit_in};
                    if (bit_cnt == 5'd4) begin
                        bit_cnt_nxt = 5'd0;
                        state_nxt   = S_REGAD;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
                S_REGAD: begin
                    reg_sh_nxt = reg_addr_full;
                    if (bit_cnt == 5'd4) begin
                        bit_cnt_nxt = 5'd0;
                        if (phy_sh != PHY_ADDR) begin
                            state_nxt = S_SKIP;
                        end else begin
                            state_nxt = S_TA;
                            if (is_rd) rd_shift_nxt = rd_val;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt == 5'd0) begin
                        bit_cnt_nxt = 5'd1;
                    end else begin
                        bit_cnt_nxt = 5'd0;
                        state_nxt   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (!is_rd) wr_shift_nxt = wr_data_full;
                    if (bit_cnt == 5'd15) begin
                        state_nxt = S_IDLE;
                        commit    = !is_rd;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
                S_SKIP: begin
                    if (bit_cnt == 5'd17) state_nxt = S_IDLE;
                    else                  bit_cnt_nxt = bit_cnt + 5'd1;
                end
                default: state_nxt = S_IDLE;
            endcase
            if (state != S_IDLE && state_nxt == S_IDLE) pre_cnt_nxt = 6'd0;
        end

        // Drive decisions happen on the fall so the MAC sees stable data at its next rise
        if (mdc_fall) begin
            if (state == S_TA && bit_cnt == 5'd1 && is_rd) begin
                oen_nxt = 1'b0;
                out_nxt = 1'b0;
            end else if (state == S_DATA && is_rd) begin
                oen_nxt      = 1'b0;
                out_nxt      = rd_shift[15];
                rd_shift_nxt = {rd_shift[14:0], 1'b0};
            end else begin
                oen_nxt = 1'b1;
                out_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            bit_cnt     <= 5'd0;
            pre_cnt     <= 6'd0;
            is_rd       <= 1'b0;
            op_hi       <= 1'b0;
            phy_sh      <= 5'd0;
            reg_sh      <= 5'd0;
            rd_shift    <= 16'd0;
            wr_shift    <= 16'd0;
            mdio_out    <= 1'b1;
            mdio_oen    <= 1'b1;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 5'd0;
            reg_wr_data <= 16'd0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            pre_cnt   <= pre_cnt_nxt;
            is_rd     <= is_rd_nxt;
            op_hi     <= op_hi_nxt;
            phy_sh    <= phy_sh_nxt;
            reg_sh    <= reg_sh_nxt;
            rd_shift  <= rd_shift_nxt;
            wr_shift  <= wr_shift_nxt;
            mdio_out  <= out_nxt;
            mdio_oen  <= oen_nxt;
            reg_wr_en <= commit;
            if (commit) begin
                reg_wr_addr <= reg_sh;
                reg_wr_data <= wr_data_full;
            end
        end
    end

    // Entries 1..3 are shadowed by live/ID values on read, so clearing them is invisible
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 16'd0;
        end else if (commit) begin
            if (reg_sh == 5'd0 && wr_data_full[15]) begin
                for (int i = 0; i < 32; i++) regs[i] <= 16'd0;
            end else if (reg_sh == 5'd0 || reg_sh >= 5'd4) begin
                regs[reg_sh] <= wr_data_full;
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: MAC-side MDC/MDIO driver with pulled-up bus model.
`timescale 1ns/1ps
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;
    logic [15:0] status_in = 16'h0000;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;

    logic mac_drv = 1'b0;
    logic mac_val = 1'b1;

    int half_ns = 40;
    int checks = 0;
    int passes = 0;
    int wr_cnt = 0;
    int oen_low_cyc = 0;

    assign mdio_in = !mdio_oen ? mdio_out : (mac_drv ? mac_val : 1'b1);

    always #5 clk = ~clk;

    mdio_responder dut (
        .clk         (clk),
        .reset       (reset),
        .mdc         (mdc),
        .mdio_in     (mdio_in),
        .mdio_out    (mdio_out),
        .mdio_oen    (mdio_oen),
        .status_in   (status_in),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data)
    );

    always @(negedge clk) begin
        if (reg_wr_en) wr_cnt++;
        if (!mdio_oen) oen_low_cyc++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic drv, input logic val, output logic seen, output logic oen_s);
        mac_drv = drv;
        mac_val = val;
        #(half_ns);
        mdc = 1'b1;
        #(half_ns - 1);
        seen  = mdio_in;
        oen_s = mdio_oen;
        #1;
        mdc = 1'b0;
    endtask

    task automatic send_hdr(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad);
        logic s, o;
        int   ph;
        ph = 2 * $urandom_range(1, 4);
        @(posedge clk);
        #(ph);
        repeat (pre) send_bit(1'b1, 1'b1, s, o);
        send_bit(1'b1, 1'b0, s, o);
        send_bit(1'b1, 1'b1, s, o);
        for (int i = 1; i >= 0; i--) send_bit(1'b1, op[i], s, o);
        for (int i = 4; i >= 0; i--) send_bit(1'b1, phy[i], s, o);
        for (int i = 4; i >= 0; i--) send_bit(1'b1, regad[i], s, o);
    endtask

    task automatic do_write(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad, input logic [15:0] data);
        logic s, o;
        send_hdr(pre, op, phy, regad);
        send_bit(1'b1, 1'b1, s, o);
        send_bit(1'b1, 1'b0, s, o);
        for (int i = 15; i >= 0; i--) send_bit(1'b1, data[i], s, o);
        mac_drv = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic do_read(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                           output logic [15:0] rdata, output logic ta1_oen, output logic ta2_oen,
                           output logic ta2_val, output int low_bits, output logic oen_after);
        logic s, o;
        send_hdr(pre, 2'b10, phy, regad);
        send_bit(1'b0, 1'b1, s, ta1_oen);
        send_bit(1'b0, 1'b1, ta2_val, ta2_oen);
        low_bits = 0;
        for (int i = 15; i >= 0; i--) begin
            send_bit(1'b0, 1'b1, s, o);
            rdata[i] = s;
            if (!o) low_bits++;
        end
        repeat (5) @(posedge clk);
        #1 oen_after = mdio_oen;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] regad, input logic [15:0] exp);
        logic [15:0] rd;
        logic        t1, t2, tv, oa;
        int          lb;
        do_read(32, 5'd1, regad, rd, t1, t2, tv, lb, oa);
        chk(tag, 32'(rd), 32'(exp));
    endtask

    logic [15:0] rd;
    logic        t1, t2, tv, oa, s, o;
    int          lb, w0, l0;
    logic [15:0] pat [3];

    initial begin
        pat[0] = 16'h3C5A;
        pat[1] = 16'h0001;
        pat[2] = 16'hFFFE;

        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_oen", 32'(mdio_oen), 32'h1);
        chk("rst_out", 32'(mdio_out), 32'h1);
        chk("rst_wr_en", 32'(reg_wr_en), 32'h0);
        chk("rst_wr_addr", 32'(reg_wr_addr), 32'h0);
        chk("rst_wr_data", 32'(reg_wr_data), 32'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);

        // write reg 4
        w0 = wr_cnt;
        do_write(32, 2'b01, 5'd1, 5'd4, 16'hA5C3);
        chk("wr4_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("wr4_addr", 32'(reg_wr_addr), 32'd4);
        chk("wr4_data", 32'(reg_wr_data), 32'hA5C3);

        // read it back with turnaround/drive-window checks
        do_read(32, 5'd1, 5'd4, rd, t1, t2, tv, lb, oa);
        chk("rd4_data", 32'(rd), 32'hA5C3);
        chk("rd4_ta1_oen", 32'(t1), 32'h1);
        chk("rd4_ta2_oen", 32'(t2), 32'h0);
        chk("rd4_ta2_val", 32'(tv), 32'h0);
        chk("rd4_drv_bits", 32'(lb), 32'd16);
        chk("rd4_release", 32'(oa), 32'h1);

        read_chk("rd_id1", 5'd2, 16'h0022);
        read_chk("rd_id2", 5'd3, 16'h1622);
        status_in = 16'h786D;
        read_chk("rd_status", 5'd1, 16'h786D);

        // read-only reg still reports the write
        w0 = wr_cnt;
        do_write(32, 2'b01, 5'd1, 5'd2, 16'hBEEF);
        chk("wr_ro_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("wr_ro_addr", 32'(reg_wr_addr), 32'd2);
        read_chk("rd_id1_after_wr", 5'd2, 16'h0022);

        // other PHY address: never drive
        l0 = oen_low_cyc;
        do_read(32, 5'd2, 5'd2, rd, t1, t2, tv, lb, oa);
        chk("skip_oen_cycles", 32'(oen_low_cyc - l0), 32'd0);
        chk("skip_bus", 32'(rd), 32'hFFFF);
        read_chk("rd4_after_skip", 5'd4, 16'hA5C3);

        // short preamble and illegal opcode are ignored
        w0 = wr_cnt;
        do_write(31, 2'b01, 5'd1, 5'd5, 16'h1234);
        chk("short_pre_pulses", 32'(wr_cnt - w0), 32'd0);
        read_chk("rd5_after_short", 5'd5, 16'h0000);
        w0 = wr_cnt;
        do_write(32, 2'b11, 5'd1, 5'd6, 16'h5555);
        chk("op11_pulses", 32'(wr_cnt - w0), 32'd0);
        read_chk("rd6_after_op11", 5'd6, 16'h0000);

        // reset in the middle of a read data phase
        send_hdr(32, 2'b10, 5'd1, 5'd4);
        send_bit(1'b0, 1'b1, s, o);
        send_bit(1'b0, 1'b1, s, o);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, s, o);
        chk("mid_rd_oen", 32'(o), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_oen", 32'(mdio_oen), 32'h1);
        chk("abort_out", 32'(mdio_out), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        read_chk("rd4_after_reset", 5'd4, 16'h0000);

        // soft reset via reg 0 bit 15
        do_write(32, 2'b01, 5'd1, 5'd4, 16'hA5C3);
        do_write(32, 2'b01, 5'd1, 5'd7, 16'h1234);
        do_write(32, 2'b01, 5'd1, 5'd31, 16'hFFFF);
        do_write(32, 2'b01, 5'd1, 5'd0, 16'h1140);
        read_chk("rd0_stored", 5'd0, 16'h1140);
        read_chk("rd31_stored", 5'd31, 16'hFFFF);
        do_write(32, 2'b01, 5'd1, 5'd0, 16'h8000);
        chk("srst_addr", 32'(reg_wr_addr), 32'd0);
        chk("srst_data", 32'(reg_wr_data), 32'h8000);
        read_chk("srst_rd0", 5'd0, 16'h0000);
        read_chk("srst_rd4", 5'd4, 16'h0000);
        read_chk("srst_rd7", 5'd7, 16'h0000);
        read_chk("srst_rd31", 5'd31, 16'h0000);
        read_chk("srst_rd_id2", 5'd3, 16'h1622);

        // MDC at clk/4 with random phase per frame
        half_ns = 20;
        for (int k = 0; k < 3; k++) begin
            w0 = wr_cnt;
            do_write(32, 2'b01, 5'd1, 5'd9, pat[k]);
            chk("fast_wr_pulses", 32'(wr_cnt - w0), 32'd1);
            chk("fast_wr_data", 32'(reg_wr_data), 32'(pat[k]));
            read_chk("fast_rd9", 5'd9, pat[k]);
            status_in = ~pat[k];
            read_chk("fast_rd_status", 5'd1, ~pat[k]);
        end
        read_chk("fast_rd_id1", 5'd2, 16'h0022);
        do_read(32, 5'd1, 5'd3, rd, t1, t2, tv, lb, oa);
        chk("fast_rd_id2", 32'(rd), 32'h1622);
        chk("fast_drv_bits", 32'(lb), 32'd16);
        chk("fast_release", 32'(oa), 32'h1);
        l0 = oen_low_cyc;
        do_read(32, 5'd0, 5'd3, rd, t1, t2, tv, lb, oa);
        chk("fast_skip_oen", 32'(oen_low_cyc - l0), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
